othello_validator: RTL



---
 rtl/othello_validator_pkg.sv | 38 +++
 rtl/othello_validator_if.sv | 32 +++
 rtl/othello_validator_addr_step.sv | 27 ++
 rtl/othello_validator.sv | 128 ++++++++++++
 4 files changed

// File: rtl/othello_validator_pkg.sv
// Shared Othello definitions: cell encoding, board geometry, step constants, validator states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package othello_pkg;

    localparam int BOARD_W = 10;
    localparam int CELLS   = 100;
    localparam int AW      = 7;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_BLACK  = 2'b01;
    localparam logic [1:0] CELL_WHITE  = 2'b10;
    localparam logic [1:0] CELL_BORDER = 2'b11;

    localparam logic [4:0] STEP_H  = 5'd1;
    localparam logic [4:0] STEP_V  = 5'd10;
    localparam logic [4:0] STEP_D1 = 5'd9;
    localparam logic [4:0] STEP_D2 = 5'd11;

    // Longest opponent run that can sit between two squares on an 8x8 board.
    localparam logic [2:0] MAX_RUN = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } val_state_t;

    function automatic logic [1:0] opponent_of(input logic player);
        return player ? CELL_BLACK : CELL_WHITE;
    endfunction

    function automatic logic [1:0] own_of(input logic player);
        return player ? CELL_WHITE : CELL_BLACK;
    endfunction

endpackage

// File: rtl/othello_validator_if.sv
// Controller and board-RAM signal bundle for the direction validator.
// Latency: none (wiring only).
// Backpressure: none; the controller polls s_done_o.
interface othello_validator_if;
    import othello_pkg::*;

    logic          ld;
    logic          enable;
    logic [AW-1:0] pos_in;
    logic [4:0]    step_in;
    logic          step_sign_in;
    logic          player_in;
    logic [AW-1:0] mem_addr_o;
    logic          mem_rd_o;
    logic [1:0]    mem_data_i;
    logic          s_done_o;
    logic          dir_status_o;
    logic [2:0]    run_len_o;

    // Controller plus RAM side.
    modport master (
        output ld, enable, pos_in, step_in, step_sign_in, player_in, mem_data_i,
        input  mem_addr_o, mem_rd_o, s_done_o, dir_status_o, run_len_o
    );

    // Validator side.
    modport slave (
        input  ld, enable, pos_in, step_in, step_sign_in, player_in, mem_data_i,
        output mem_addr_o, mem_rd_o, s_done_o, dir_status_o, run_len_o
    );

endinterface

// File: rtl/othello_validator_addr_step.sv
// Board address stepper: cur +/- step with an out-of-board flag (borrow or >= CELLS).
// Latency: combinational.
// Backpressure: none.
module board_addr_step
    import othello_pkg::*;
(
    input  logic [AW-1:0] cur,
    input  logic [4:0]    step,
    input  logic          sign,
    output logic [AW-1:0] nxt,
    output logic          oob
);

    localparam logic [AW:0] CELLS_X = (AW+1)'(CELLS);

    logic [AW:0] step_x;
    logic [AW:0] full;

    // One extra bit catches both the subtract borrow and the add overflow.
    always_comb begin
        step_x = {{(AW+1-5){1'b0}}, step};
        full   = sign ? ({1'b0, cur} - step_x) : ({1'b0, cur} + step_x);
        nxt    = full[AW-1:0];
        oob    = full[AW] | (full >= CELLS_X);
    end

endmodule

// File: rtl/othello_validator.sv
// Walks one direction from a candidate square and reports whether it brackets opponent discs.
// Latency: 2 cycles per examined cell; done in cycle 2k+1 (cycle 2 if first step leaves the board).
// Backpressure: none; ld/enable ignored mid-walk, result held in DONE until the next enable.
module othello_validator
    import othello_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    othello_validator_if.slave  bus
);

    val_state_t    state;
    logic [AW-1:0] pos_r;
    logic [AW-1:0] cur;
    logic [4:0]    step_r;
    logic          sign_r;
    logic          player_r;
    logic [2:0]    run;
    logic          bad;

    logic [AW-1:0] base;
    logic [4:0]    stp;
    logic          sgn;
    logic [AW-1:0] nxt;
    logic          oob;

    // Step source: the next cell is computed one state early so the read strobe can be registered.
    // From IDLE/DONE it uses the values being loaded this cycle when ld is high.
    always_comb begin
        base = pos_r;
        stp  = step_r;
        sgn  = sign_r;
        if (state == CHECK) begin
            base = cur;
        end else if (bus.ld) begin
            base = bus.pos_in;
            stp  = bus.step_in;
            sgn  = bus.step_sign_in;
        end
    end

    board_addr_step u_step (
        .cur  (base),
        .step (stp),
        .sign (sgn),
        .nxt  (nxt),
        .oob  (oob)
    );

    // Walk state machine with registered outputs; the read address only moves when a read is issued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            pos_r            <= '0;
            cur              <= '0;
            step_r           <= '0;
            sign_r           <= 1'b0;
            player_r         <= 1'b0;
            run              <= '0;
            bad              <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_rd_o     <= 1'b0;
            bus.s_done_o     <= 1'b0;
            bus.dir_status_o <= 1'b0;
            bus.run_len_o    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.ld) begin
                        pos_r    <= bus.pos_in;
                        step_r   <= bus.step_in;
                        sign_r   <= bus.step_sign_in;
                        player_r <= bus.player_in;
                    end
                    if (bus.enable) begin
                        run              <= '0;
                        bus.s_done_o     <= 1'b0;
                        bus.dir_status_o <= 1'b0;
                        bus.run_len_o    <= '0;
                        bad              <= oob;
                        if (!oob) begin
                            cur            <= nxt;
                            bus.mem_addr_o <= nxt;
                            bus.mem_rd_o   <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_rd_o <= 1'b0;
                    if (bad) begin
                        bus.s_done_o <= 1'b1;
                        state        <= DONE;
                    end else begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (bus.mem_data_i == opponent_of(player_r)) begin
                        if (run == MAX_RUN) begin
                            bus.s_done_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            run <= run + 3'd1;
                            bad <= oob;
                            if (!oob) begin
                                cur            <= nxt;
                                bus.mem_addr_o <= nxt;
                                bus.mem_rd_o   <= 1'b1;
                            end
                            state <= ISSUE;
                        end
                    end else if (bus.mem_data_i == own_of(player_r) && run != 3'd0) begin
                        bus.s_done_o     <= 1'b1;
                        bus.dir_status_o <= 1'b1;
                        bus.run_len_o    <= run;
                        state            <= DONE;
                    end else begin
                        bus.s_done_o <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
